// File: rtl/ffmul_seq_ctrl.sv
// rtl/ffmul_seq_ctrl.sv - operand sequencer and result collector for a word-serial systolic GF multiplier
// Streams b MS-word first with a/g one cycle behind, then gathers N product words after LAT cycles.
module ffmul_seq_ctrl #(
  parameter int WEIGHT = 16,
  parameter int N      = 11,
  parameter int LAT    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [WEIGHT*N-1:0] a_op,
  input  logic [WEIGHT*N-1:0] b_op,
  input  logic [WEIGHT*N-1:0] g_op,
  output logic                mul_ctr,
  output logic [WEIGHT-1:0]   mul_ai,
  output logic [WEIGHT-1:0]   mul_bi,
  output logic [WEIGHT-1:0]   mul_gi,
  input  logic [WEIGHT-1:0]   mul_po,
  output logic [WEIGHT*N-1:0] res,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);
  localparam int W  = WEIGHT * N;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] FEED_LAST = CW'(N);
  localparam logic [CW-1:0] COL_LAST  = CW'(N - 1);
  localparam logic [7:0]    WAIT_LAST = 8'(LAT - 1);

  if (LAT < N + 1 || LAT > 255) begin : g_lat_range
    $error("ffmul_seq_ctrl: LAT must lie in N+1..255");
  end

  typedef enum logic [2:0] {IDLE, FEED, WAIT, COLLECT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  word_cnt;
  logic [7:0]     lat_cnt;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   g_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid)           state_nxt = FEED;
      FEED:    if (word_cnt == FEED_LAST) state_nxt = WAIT;
      WAIT:    if (lat_cnt == WAIT_LAST)  state_nxt = COLLECT;
      COLLECT: if (word_cnt == COL_LAST)  state_nxt = DONE;
      DONE:    if (res_ready)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // lat_cnt counts from the first mul_ctr=1 feed cycle, so it holds that cycle's index.
  // Operands drain through shift registers; the top word is always the one on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      lat_cnt  <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      g_sh     <= '0;
      res      <= '0;
    end else begin
      case (state)
        IDLE: begin
          word_cnt <= '0;
          lat_cnt  <= '0;
          if (start_valid) begin
            a_sh <= a_op;
            b_sh <= b_op;
            g_sh <= g_op;
          end
        end
        FEED: begin
          b_sh     <= b_sh << WEIGHT;
          word_cnt <= (word_cnt == FEED_LAST) ? '0 : word_cnt + 1'b1;
          if (word_cnt != '0) begin
            a_sh    <= a_sh << WEIGHT;
            g_sh    <= g_sh << WEIGHT;
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        WAIT: begin
          lat_cnt  <= lat_cnt + 8'd1;
          word_cnt <= '0;
        end
        COLLECT: begin
          res      <= (res << WEIGHT) | W'(mul_po);
          word_cnt <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    mul_ctr     = 1'b1;
    mul_ai      = '0;
    mul_bi      = '0;
    mul_gi      = '0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        mul_ctr     = 1'b0;
      end
      FEED: begin
        mul_bi = b_sh[W-1 -: WEIGHT];
        if (word_cnt == '0) begin
          mul_ctr = 1'b0;
        end else begin
          mul_ai = a_sh[W-1 -: WEIGHT];
          mul_gi = g_sh[W-1 -: WEIGHT];
        end
      end
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: doc/ffmul_seq_ctrl.md
FFMUL_SEQ_CTRL -- requirements
Module: ffmul_seq_ctrl

Interface
REQ-001 SHALL have parameter WEIGHT, default 16, word width in bits of the systolic multiplier.
REQ-002 SHALL have parameter N, default 11, number of words per operand (operand width WEIGHT*N = 176).
REQ-003 SHALL have parameter LAT, default 24, cycles from first mul_ctr=1 cycle to first valid mul_po word; legal range N+1..255, out-of-range is an elaboration error.
REQ-004 Ports: clk  in  1  clock; all state updates on rising edge.
REQ-005 Ports: rst  in  1  asynchronous active-low reset.
REQ-006 Ports: start_valid  in  1  operand set offered; start_ready  out  1  controller accepts operands.
REQ-007 Ports: a_op, b_op, g_op  in  WEIGHT*N each  operands and field polynomial; word k = bits [(k+1)*WEIGHT-1 : k*WEIGHT].
REQ-008 Ports: mul_ctr  out  1  multiplier control; mul_ai, mul_bi, mul_gi  out  WEIGHT each  word streams to multiplier.
REQ-009 Ports: mul_po  in  WEIGHT  multiplier product word.
REQ-010 Ports: res  out  WEIGHT*N  assembled product; res_valid  out  1; res_ready  in  1.
REQ-011 Ports: busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, FEED, WAIT, COLLECT, DONE.
REQ-013 start_ready SHALL be 1 only in IDLE; transfer occurs on a cycle with start_valid=1 and start_ready=1.
REQ-014 On transfer, a_op/b_op/g_op SHALL be registered and FSM SHALL go to FEED; operands changing afterward have no effect.
REQ-015 FEED lasts N+1 cycles, index f=0..N: f=0 -> mul_ctr=0, mul_bi=b word N-1, mul_ai=mul_gi=0.
REQ-016 FEED f=1..N-1 -> mul_ctr=1, mul_bi=b word N-1-f, mul_ai=a word N-f, mul_gi=g word N-f (a/g lag b by one cycle).
REQ-017 FEED f=N -> mul_ctr=1, mul_bi=0, mul_ai=a word 0, mul_gi=g word 0; then FEED->WAIT.
REQ-018 In WAIT, COLLECT and DONE: mul_ctr=1, mul_ai=mul_bi=mul_gi=0.
REQ-019 An 8-bit latency counter SHALL start at FEED f=1 (first mul_ctr=1 cycle = cycle 0); WAIT->COLLECT such that first capture occurs at cycle LAT.
REQ-020 COLLECT captures mul_po on N consecutive cycles; first captured word = res word N-1, last = res word 0 (MS word first); then COLLECT->DONE.
REQ-021 mul_po bit order: mul_po[WEIGHT-1] is stored as the MSB of the captured word, no bit reversal.
REQ-022 In DONE, res_valid=1 and res stable; on res_valid=1 and res_ready=1, FSM->IDLE, res_valid=0 next cycle, res retains last value.
REQ-023 res_ready=1 in any state other than DONE SHALL be ignored.
REQ-024 In IDLE, mul_ctr=0 and all mul_* word outputs = 0.
REQ-025 Back-to-back: start accepted in the IDLE cycle immediately after DONE handshake; no bubble beyond that IDLE cycle is required.
REQ-026 Total accept-to-res_valid latency SHALL be exactly 1+LAT+N+1 cycles (LAT=24, N=11: 37 cycles).

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, counters=0, operand registers=0, res=0, res_valid=0, busy=0, start_ready=1 after release, mul_ctr=0, mul_ai/bi/gi=0.
REQ-028 Reset asserted mid-operation (any of FEED/WAIT/COLLECT/DONE) SHALL abort the operation; no partial res is exposed; first post-reset cycle is IDLE.

Verification
REQ-029 Single op: a=176'h...2000_2000_C020_0801..., b, g as the team's standard 176-bit vector, LAT=24 -> mul_* streams match REQ-015..017 cycle-by-cycle; res_valid at cycle 37 after accept.
REQ-030 Stream order: a=word k value k+1, b=word k value 16'h100+k, g=0 -> f=0 bi=16'h10A ctr=0; f=1 bi=16'h109 ai=16'h000B; f=11 bi=0 ai=16'h0001.
REQ-031 Collection: drive mul_po=16'hF000+cycle index from cycle 24 -> res word 10=16'hF018, res word 0=16'hF022 (cycles 24..34).
REQ-032 Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid stays 1, res stable, start_ready=0; res_ready=1 -> IDLE next cycle.
REQ-033 Reset mid-COLLECT (cycle 28): rst=0 -> same cycle mul_ctr=0, res_valid=0, busy=0; after release, new op completes correctly.
REQ-034 Back-to-back two ops with start_valid held 1 -> second accepted in IDLE cycle after first DONE handshake; both results correct.
